via_timer_bank: RTL

//  Parametrised timer/counter bank for the VIA-style peripheral subsystem.

---
 rtl/via_timer_bank.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/via_timer_bank.sv
// via_timer_bank: bank of NUM_CH down-counters with reload latches, per-channel
// mode (one-shot / free-run square wave / external pulse counting), a shared
// IFR/IER pair and one level interrupt. Bus-compatible with the via6522 map.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   cs, rw, addr    bus select, 1=read/0=write, {channel[5:3], register[2:0]}
//   dataIn/dataOut  write data / registered read data
//   pulse_in        asynchronous per-channel count inputs
//   tmr_out         per-channel timer output
//   irq             registered |(IFR & IER)
module via_timer_bank #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned TIMER_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              rw,
  input  logic [5:0]        addr,
  input  logic [7:0]        dataIn,
  output logic [7:0]        dataOut,
  input  logic [NUM_CH-1:0] pulse_in,
  output logic [NUM_CH-1:0] tmr_out,
  output logic              irq
);

  localparam int unsigned HI_W = TIMER_W - 8;

  localparam logic [2:0] GLOBAL_CH = 3'd7;
  localparam logic [2:0] REG_CNT_L = 3'd0;
  localparam logic [2:0] REG_CNT_H = 3'd1;
  localparam logic [2:0] REG_LAT_L = 3'd2;
  localparam logic [2:0] REG_LAT_H = 3'd3;
  localparam logic [2:0] REG_CTRL  = 3'd4;
  localparam logic [2:0] REG_IFR   = 3'd0;
  localparam logic [2:0] REG_IER   = 3'd1;

  // Per-channel state
  logic [TIMER_W-1:0] cnt_q  [NUM_CH];
  logic [TIMER_W-1:0] cnt_d  [NUM_CH];
  logic [TIMER_W-1:0] lat_q  [NUM_CH];
  logic [TIMER_W-1:0] lat_d  [NUM_CH];
  logic [1:0]         ctrl_q [NUM_CH];
  logic [1:0]         ctrl_d [NUM_CH];
  logic [NUM_CH-1:0]  armed_q, armed_d;
  logic [NUM_CH-1:0]  tmr_q, tmr_d;
  logic [NUM_CH-1:0]  ifr_q, ifr_d;
  logic [NUM_CH-1:0]  sync1_q, sync1_d;
  logic [NUM_CH-1:0]  sync2_q, sync2_d;
  logic [NUM_CH-1:0]  pls_prev_q, pls_prev_d;

  // Shared state
  logic [6:0] ier_q, ier_d;
  logic       irq_q, irq_d;
  logic [7:0] dout_q, dout_d;

  // Bus decode
  logic              rd_en;
  logic              wr_en;
  logic [2:0]        ch_sel;
  logic [2:0]        reg_sel;
  logic              ch_hit;
  logic              glb_hit;
  logic [NUM_CH-1:0] ch_dec;
  logic [NUM_CH-1:0] pls_rise;
  logic [7:0]        rdata;

  assign rd_en   = cs & rw;
  assign wr_en   = cs & ~rw;
  assign ch_sel  = addr[5:3];
  assign reg_sel = addr[2:0];
  assign ch_hit  = (32'(ch_sel) < NUM_CH);
  assign glb_hit = (ch_sel == GLOBAL_CH);

  // Rising edge seen at the output of the 2-flop synchroniser
  assign pls_rise = sync2_q & ~pls_prev_q;

  // One-hot channel select for mapped channels
  always_comb begin
    ch_dec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_dec[i] = ch_hit && (ch_sel == 3'(i));
    end
  end

  // Read data mux
  always_comb begin
    rdata = '0;
    if (glb_hit) begin
      case (reg_sel)
        REG_IFR: begin
          rdata    = 8'(ifr_q);
          rdata[7] = |(ifr_q & ier_q[NUM_CH-1:0]);
        end
        REG_IER: rdata = {1'b1, ier_q};
        default: rdata = '0;
      endcase
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_dec[i]) begin
          case (reg_sel)
            REG_CNT_L: rdata = cnt_q[i][7:0];
            REG_CNT_H: rdata = 8'(cnt_q[i][TIMER_W-1:8]);
            REG_LAT_L: rdata = lat_q[i][7:0];
            REG_LAT_H: rdata = 8'(lat_q[i][TIMER_W-1:8]);
            REG_CTRL:  rdata = {6'b0, ctrl_q[i]};
            default:   rdata = '0;
          endcase
        end
      end
    end
  end

  // Next-state logic. Order matters: clears first, then zero-event sets,
  // then a CNT_H write, so that "set beats clear" and "write beats event".
  always_comb begin
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    ctrl_d     = ctrl_q;
    armed_d    = armed_q;
    tmr_d      = tmr_q;
    ifr_d      = ifr_q;
    ier_d      = ier_q;
    sync1_d    = pulse_in;
    sync2_d    = sync1_q;
    pls_prev_d = sync2_q;
    irq_d      = |(ifr_q & ier_q[NUM_CH-1:0]);
    dout_d     = rd_en ? rdata : dout_q;

    if (wr_en && glb_hit && (reg_sel == REG_IER)) begin
      if (dataIn[7]) ier_d = ier_q | dataIn[6:0];
      else           ier_d = ier_q & ~dataIn[6:0];
    end

    for (int i = 0; i < NUM_CH; i++) begin
      // Flag clears: CNT_L read, IFR write-1-to-clear, LAT_H write
      if (rd_en && ch_dec[i] && (reg_sel == REG_CNT_L)) ifr_d[i] = 1'b0;
      if (wr_en && glb_hit && (reg_sel == REG_IFR) && dataIn[i]) ifr_d[i] = 1'b0;

      if (wr_en && ch_dec[i]) begin
        case (reg_sel)
          REG_CNT_L, REG_LAT_L: lat_d[i][7:0] = dataIn;
          REG_LAT_H: begin
            lat_d[i][TIMER_W-1:8] = dataIn[HI_W-1:0];
            ifr_d[i]              = 1'b0;
          end
          REG_CTRL:  ctrl_d[i] = dataIn[1:0];
          default: ;
        endcase
      end

      // Decrement: every clk, or on a synchronised pulse edge in pulse mode
      if (ctrl_q[i][1] ? pls_rise[i] : 1'b1) begin
        if (cnt_q[i] == '0) begin
          if (ctrl_q[i][0]) begin
            ifr_d[i] = 1'b1;
            cnt_d[i] = lat_q[i];
            tmr_d[i] = ~tmr_q[i];
          end else begin
            if (armed_q[i]) begin
              ifr_d[i]   = 1'b1;
              armed_d[i] = 1'b0;
              tmr_d[i]   = 1'b1;
            end
            cnt_d[i] = cnt_q[i] - TIMER_W'(1);
          end
        end else begin
          cnt_d[i] = cnt_q[i] - TIMER_W'(1);
        end
      end

      // CNT_H write restarts the channel and overrides a same-edge zero event
      if (wr_en && ch_dec[i] && (reg_sel == REG_CNT_H)) begin
        lat_d[i][TIMER_W-1:8] = dataIn[HI_W-1:0];
        cnt_d[i]              = {dataIn[HI_W-1:0], lat_q[i][7:0]};
        ifr_d[i]              = 1'b0;
        armed_d[i]            = 1'b1;
        if (!ctrl_q[i][0]) tmr_d[i] = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        lat_q[i]  <= '0;
        ctrl_q[i] <= '0;
      end
      armed_q    <= '0;
      tmr_q      <= '1;
      ifr_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      pls_prev_q <= '0;
      ier_q      <= '0;
      irq_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      ctrl_q     <= ctrl_d;
      armed_q    <= armed_d;
      tmr_q      <= tmr_d;
      ifr_q      <= ifr_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      pls_prev_q <= pls_prev_d;
      ier_q      <= ier_d;
      irq_q      <= irq_d;
      dout_q     <= dout_d;
    end
  end

  assign dataOut = dout_q;
  assign tmr_out = tmr_q;
  assign irq     = irq_q;

endmodule
